// File: rtl/npc_pkg.sv
// Shared writeback types and constants for the register-file write path.
// Pure declarations: no latency, no flow control.
package npc_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus plus register-file write port and pending mask.
// Wiring only; requesters hold valid/addr/data until they see ready.
interface regfile_wb_arbiter_if #(
    parameter int NREQ       = 3,
    parameter int ADDR_WIDTH = npc_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = npc_pkg::DATA_WIDTH
);

    logic                       hold;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       rf_wen;
    logic [ADDR_WIDTH-1:0]      rf_waddr;
    logic [DATA_WIDTH-1:0]      rf_wdata;
    logic [2**ADDR_WIDTH-1:0]   pend_mask;

    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, rf_wen, rf_waddr, rf_wdata, pend_mask
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, rf_wen, rf_waddr, rf_wdata, pend_mask
    );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grant is combinational, pointer moves past the winner on advance.
// Zero-latency grant; en low suppresses all grants without moving the pointer.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          advance,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW:0]   cand;
    logic          found;

    // Scan offsets 0..N-1 from the pointer; the first requesting slot wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            for (int j = 0; j < N; j++) begin
                if (en && !found && cand == (IW+1)'(j) && req[j]) begin
                    gnt[j]  = 1'b1;
                    gnt_idx = IW'(j);
                    found   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port; winner staged one cycle, then written.
// Grant is combinational from valid/hold/pointer; hold stalls grants, the RF never backpressures.
module regfile_wb_arbiter #(
    parameter int NREQ       = 3,
    parameter int ADDR_WIDTH = npc_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = npc_pkg::DATA_WIDTH
) (
    input logic               clk,
    input logic               rst,
    regfile_wb_arbiter_if.slave wb
);

    import npc_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t                  reqs [NREQ];
    req_t                  win;
    logic [NREQ-1:0]       gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  hs;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [2**ADDR_WIDTH-1:0] pend;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqs[i].addr = wb.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            reqs[i].data = wb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Grants are withheld while in reset so nothing is accepted that would be lost.
    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (rst && !wb.hold),
        .advance (hs),
        .req     (wb.req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign hs           = |(wb.req_valid & gnt);
    assign wb.req_ready = gnt;

    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                win = reqs[i];
            end
        end
    end

    // Writes to x0 are accepted but never enabled toward the register file.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (hs) begin
            wen_q   <= (win.addr != ADDR_WIDTH'(REG_ZERO));
            waddr_q <= win.addr;
            wdata_q <= win.data;
        end else begin
            wen_q   <= 1'b0;
        end
    end

    always_comb begin
        pend = '0;
        if (wen_q) begin
            pend[waddr_q] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    assign wb.rf_wen    = wen_q;
    assign wb.rf_waddr  = waddr_q;
    assign wb.rf_wdata  = wdata_q;
    assign wb.pend_mask = pend;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios then randomized traffic, checked against a queue-free behavioural model.
module tb_regfile_wb_arbiter;

    import npc_pkg::*;

    localparam int NREQ = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus();

    regfile_wb_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    int tests = 0;
    int fails = 0;

    wb_req_t               req_m [NREQ];
    int                    m_ptr   = 0;
    logic                  m_wen   = 1'b0;
    logic [ADDR_WIDTH-1:0] m_waddr = '0;
    logic [DATA_WIDTH-1:0] m_wdata = '0;
    logic [NREQ-1:0]       m_gnt   = '0;
    logic [NREQ-1:0]       v_cur;

    function automatic logic [NREQ-1:0] ref_grant(logic r, logic h, logic [NREQ-1:0] v, int p);
        logic [NREQ-1:0] g = '0;
        if (r && !h) begin
            for (int k = 0; k < NREQ; k++) begin
                int i = (p + k) % NREQ;
                if (v[i] && g == '0) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic h, input logic [NREQ-1:0] v);
        logic [2**ADDR_WIDTH-1:0] exp_pend;
        rst           = r;
        bus.hold      = h;
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = req_m[i].addr;
            bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = req_m[i].data;
        end
        @(negedge clk);
        m_gnt = ref_grant(r, h, v, m_ptr);
        check("req_ready", 64'(bus.req_ready), 64'(m_gnt));
        @(posedge clk);
        if (!r) begin
            m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        end else if (m_gnt != '0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_gnt[i]) begin
                    m_wen   = (req_m[i].addr != 0);
                    m_waddr = req_m[i].addr;
                    m_wdata = req_m[i].data;
                    m_ptr   = (i + 1) % NREQ;
                end
            end
        end else begin
            m_wen = 1'b0;
        end
        #1;
        exp_pend = '0;
        if (m_wen) exp_pend[m_waddr] = 1'b1;
        check("rf_wen",    64'(bus.rf_wen),    64'(m_wen));
        check("rf_waddr",  64'(bus.rf_waddr),  64'(m_waddr));
        check("rf_wdata",  64'(bus.rf_wdata),  64'(m_wdata));
        check("pend_mask", 64'(bus.pend_mask), 64'(exp_pend));
    endtask

    initial begin
        rst = 1'b0; bus.hold = 1'b0; bus.req_valid = '0;
        bus.req_addr = '0; bus.req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_m[i].addr = ADDR_WIDTH'(i + 1);
            req_m[i].data = 32'h1000_0000 + DATA_WIDTH'(i);
        end
        @(posedge clk); #1;

        // Reset held two cycles with every requester valid
        cycle(1'b0, 1'b0, 3'b111);
        cycle(1'b0, 1'b0, 3'b111);

        // Round-robin rotation from a fresh pointer
        for (int n = 0; n < 6; n++) cycle(1'b1, 1'b0, 3'b111);

        // Single requester
        req_m[1].addr = 5'd5; req_m[1].data = 32'hDEAD_BEEF;
        cycle(1'b1, 1'b0, 3'b010);
        check("single_wen",   64'(bus.rf_wen),       64'd1);
        check("single_waddr", 64'(bus.rf_waddr),     64'd5);
        check("single_wdata", 64'(bus.rf_wdata),     64'hDEAD_BEEF);
        check("single_pend5", 64'(bus.pend_mask[5]), 64'd1);

        // x0 write: accepted, never enabled, pointer still moves
        req_m[0].addr = '0; req_m[0].data = 32'd1;
        cycle(1'b1, 1'b0, 3'b001);
        check("x0_wen",  64'(bus.rf_wen),    64'd0);
        check("x0_pend", 64'(bus.pend_mask), 64'd0);
        cycle(1'b1, 1'b0, 3'b111);

        // hold with a staged write in flight
        req_m[2].addr = 5'd9; req_m[2].data = 32'hCAFE_0009;
        cycle(1'b1, 1'b0, 3'b100);
        check("pre_hold_wen", 64'(bus.rf_wen), 64'd1);
        req_m[0].addr = 5'd3; req_m[0].data = 32'h0000_0303;
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 1'b1, 3'b101);
            check("hold_wen", 64'(bus.rf_wen), 64'd0);
        end
        cycle(1'b1, 1'b0, 3'b101);
        check("release_waddr", 64'(bus.rf_waddr), 64'd3);

        // Reset while a request is offered, then reset over a staged write
        req_m[0].addr = 5'd7; req_m[0].data = 32'h7777_7777;
        cycle(1'b0, 1'b0, 3'b001);
        check("rst_req_wen", 64'(bus.rf_wen), 64'd0);
        req_m[1].addr = 5'd7; req_m[1].data = 32'h0707_0707;
        cycle(1'b1, 1'b0, 3'b010);
        cycle(1'b0, 1'b0, 3'b000);
        check("rst_staged_wen", 64'(bus.rf_wen), 64'd0);
        cycle(1'b1, 1'b0, 3'b111);

        // Randomized traffic; requesters keep their request until granted
        v_cur = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_gnt[i] || !v_cur[i]) begin
                    v_cur[i]      = ($urandom_range(0, 9) < 6);
                    req_m[i].addr = ADDR_WIDTH'($urandom_range(0, 31));
                    req_m[i].data = $urandom;
                end
            end
            cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) == 0), v_cur);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
